ram8x8_access_ctrl: RTL and testbench

Sequencer and two-port arbiter for the 8-word x 8-bit 8T SRAM array. It accepts read/write requests from two requesters and grants one at a time, round-robin. For the granted request it drives the 3-bit wordline address and the read/write wordline-decoder enables. It also sequences read-bitline precharge, wordline assertion, sense-enable and write-bitline drive, and returns read data through a req/ack handshake.

---
 rtl/ram8x8_access_ctrl.sv | 113 +++++++++++
 tb/tb_ram8x8_access_ctrl.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ram8x8_access_ctrl.sv
// Round-robin two-port arbiter and access sequencer for the 8x8 8T SRAM array.
// Drives decoder enables, precharge, sense and write-bitline controls; returns read data via req/ack.
module ram8x8_access_ctrl #(
    parameter int PRE_CYCLES = 1,
    parameter int ACC_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       r0_req,
    input  logic       r1_req,
    input  logic       r0_we,
    input  logic       r1_we,
    input  logic [2:0] r0_addr,
    input  logic [2:0] r1_addr,
    input  logic [7:0] r0_wdata,
    input  logic [7:0] r1_wdata,
    output logic       r0_ack,
    output logic       r1_ack,
    output logic [7:0] rdata,
    output logic [2:0] dec_a,
    output logic       wwl_en,
    output logic       rwl_en,
    output logic       pre,
    output logic       sae,
    output logic [7:0] wbl,
    output logic       wbl_oe,
    input  logic [7:0] rbl
);

    typedef enum logic [2:0] {IDLE, PRE, READ, SENSE, WRITE, DONE} state_t;

    localparam logic [3:0] PRE_LOAD = 4'(PRE_CYCLES - 1);
    localparam logic [3:0] ACC_LOAD = 4'(ACC_CYCLES - 1);

    state_t     state, state_nx;
    logic [3:0] cnt, cnt_nx;
    logic       last_grant;
    logic [7:0] wdata_q;
    logic       req_any;
    logic       gnt;
    logic       gnt_we;

    // On a tie the requester not served last wins; otherwise whoever is asking.
    assign req_any = r0_req | r1_req;
    assign gnt     = (r0_req & r1_req) ? ~last_grant : r1_req;
    assign gnt_we  = gnt ? r1_we : r0_we;

    always_comb begin
        // NOTE: defaults first so every path assigns every variable; no latches.
        state_nx = state;
        cnt_nx   = cnt;
        unique case (state)
            IDLE: begin
                if (req_any) begin
                    state_nx = gnt_we ? WRITE : PRE;
                    cnt_nx   = gnt_we ? ACC_LOAD : PRE_LOAD;
                end
            end
            PRE: begin
                if (cnt == 4'd0) begin
                    state_nx = READ;
                    cnt_nx   = ACC_LOAD;
                end else begin
                    cnt_nx = cnt - 4'd1;
                end
            end
            READ: begin
                if (cnt == 4'd0) state_nx = SENSE;
                else             cnt_nx   = cnt - 4'd1;
            end
            SENSE:   state_nx = DONE;
            WRITE: begin
                if (cnt == 4'd0) state_nx = DONE;
                else             cnt_nx   = cnt - 4'd1;
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Array controls decode straight from state so reset kills them asynchronously.
    assign pre    = (state == PRE);
    assign rwl_en = (state == READ) || (state == SENSE);
    assign sae    = (state == SENSE);
    assign wwl_en = (state == WRITE);
    assign wbl_oe = (state == WRITE);
    assign wbl    = (state == WRITE) ? wdata_q : 8'h00;
    assign r0_ack = (state == DONE) && !last_grant;
    assign r1_ack = (state == DONE) &&  last_grant;

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= 4'd0;
            last_grant <= 1'b1;
            dec_a      <= 3'd0;
            wdata_q    <= 8'h00;
            rdata      <= 8'h00;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            if (state == IDLE && req_any) begin
                last_grant <= gnt;
                dec_a      <= gnt ? r1_addr  : r0_addr;
                wdata_q    <= gnt ? r1_wdata : r0_wdata;
            end
            // rbl is sampled once at the edge ending SENSE.
            if (state == SENSE) rdata <= rbl;
        end
    end

endmodule

// File: tb/tb_ram8x8_access_ctrl.sv
// Directed bench for ram8x8_access_ctrl: vector table for single transactions,
// plus reset, arbitration and parameter-sweep sequences against a behavioural array.
module tb_ram8x8_access_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       r0_req, r1_req, r0_we, r1_we;
    logic [2:0] r0_addr, r1_addr;
    logic [7:0] r0_wdata, r1_wdata;
    logic [7:0] rbl;

    logic       r0_ack, r1_ack, wwl_en, rwl_en, pre, sae, wbl_oe;
    logic [7:0] rdata, wbl;
    logic [2:0] dec_a;

    logic       b_r0_ack, b_r1_ack, b_wwl_en, b_rwl_en, b_pre, b_sae, b_wbl_oe;
    logic [7:0] b_rdata, b_wbl;
    logic [2:0] b_dec_a;

    int checks = 0;
    int errors = 0;

    logic [7:0] mem [8];

    always #5 clk = ~clk;

    ram8x8_access_ctrl dut (
        .clk(clk), .rst(rst),
        .r0_req(r0_req), .r1_req(r1_req), .r0_we(r0_we), .r1_we(r1_we),
        .r0_addr(r0_addr), .r1_addr(r1_addr), .r0_wdata(r0_wdata), .r1_wdata(r1_wdata),
        .r0_ack(r0_ack), .r1_ack(r1_ack), .rdata(rdata), .dec_a(dec_a),
        .wwl_en(wwl_en), .rwl_en(rwl_en), .pre(pre), .sae(sae),
        .wbl(wbl), .wbl_oe(wbl_oe), .rbl(rbl)
    );

    ram8x8_access_ctrl #(.PRE_CYCLES(3), .ACC_CYCLES(1)) dut_b (
        .clk(clk), .rst(rst),
        .r0_req(r0_req), .r1_req(r1_req), .r0_we(r0_we), .r1_we(r1_we),
        .r0_addr(r0_addr), .r1_addr(r1_addr), .r0_wdata(r0_wdata), .r1_wdata(r1_wdata),
        .r0_ack(b_r0_ack), .r1_ack(b_r1_ack), .rdata(b_rdata), .dec_a(b_dec_a),
        .wwl_en(b_wwl_en), .rwl_en(b_rwl_en), .pre(b_pre), .sae(b_sae),
        .wbl(b_wbl), .wbl_oe(b_wbl_oe), .rbl(rbl)
    );

    // Behavioural array: read bitlines follow the decoded word, writes land on the edge.
    assign rbl = mem[dec_a];
    always @(posedge clk) if (wwl_en && wbl_oe) mem[dec_a] <= wbl;

    always @(negedge clk) begin
        if ((pre && rwl_en) || (wwl_en && rwl_en) || (b_pre && b_rwl_en) || (b_wwl_en && b_rwl_en)) begin
            errors++;
            $display("FAIL exclusion: pre=%b rwl=%b wwl=%b b_pre=%b b_rwl=%b b_wwl=%b required no overlap",
                     pre, rwl_en, wwl_en, b_pre, b_rwl_en, b_wwl_en);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    // One transaction on one requester; records per-cycle control masks until ack.
    task automatic run_txn(input bit use_b, input bit sel, input bit we, input logic [2:0] addr,
                           input logic [7:0] wdata, output int ack_cyc,
                           output logic [15:0] m_pre, output logic [15:0] m_rwl,
                           output logic [15:0] m_sae, output logic [15:0] m_wwl,
                           output logic [15:0] m_oe, output logic [7:0] wbl_seen,
                           output logic [7:0] rd_ack, output logic [2:0] deca_ack,
                           output bit other_ack);
        ack_cyc = -1; m_pre = '0; m_rwl = '0; m_sae = '0; m_wwl = '0; m_oe = '0;
        wbl_seen = '0; rd_ack = '0; deca_ack = '0; other_ack = 1'b0;
        @(negedge clk);
        if (sel) begin r1_we = we; r1_addr = addr; r1_wdata = wdata; r1_req = 1'b1; end
        else     begin r0_we = we; r0_addr = addr; r0_wdata = wdata; r0_req = 1'b1; end
        for (int k = 1; k < 16; k++) begin
            @(negedge clk);
            if (k == 1) begin
                // Scramble the request fields after the grant; the transaction must not notice.
                if (sel) begin r1_we = ~we; r1_addr = ~addr; r1_wdata = ~wdata; end
                else     begin r0_we = ~we; r0_addr = ~addr; r0_wdata = ~wdata; end
                wbl_seen = use_b ? b_wbl : wbl;
            end
            m_pre[k] = use_b ? b_pre    : pre;
            m_rwl[k] = use_b ? b_rwl_en : rwl_en;
            m_sae[k] = use_b ? b_sae    : sae;
            m_wwl[k] = use_b ? b_wwl_en : wwl_en;
            m_oe[k]  = use_b ? b_wbl_oe : wbl_oe;
            if (use_b ? (sel ? b_r0_ack : b_r1_ack) : (sel ? r0_ack : r1_ack)) other_ack = 1'b1;
            if (use_b ? (sel ? b_r1_ack : b_r0_ack) : (sel ? r1_ack : r0_ack)) begin
                ack_cyc  = k;
                rd_ack   = use_b ? b_rdata : rdata;
                deca_ack = use_b ? b_dec_a : dec_a;
                break;
            end
        end
        r0_req = 1'b0;
        r1_req = 1'b0;
    endtask

    typedef struct {
        bit         sel;
        bit         we;
        logic [2:0] addr;
        logic [7:0] wdata;
        logic [7:0] exp_rdata;
        int         exp_ack;
        logic [15:0] exp_pre;
        logic [15:0] exp_rwl;
        logic [15:0] exp_sae;
        logic [15:0] exp_wwl;
    } vec_t;

    vec_t vecs [9];

    task automatic check_txn(input string tag, input bit use_b, input vec_t v);
        int          ack_cyc;
        logic [15:0] m_pre, m_rwl, m_sae, m_wwl, m_oe;
        logic [7:0]  wbl_seen, rd_ack;
        logic [2:0]  deca_ack;
        bit          other_ack;
        run_txn(use_b, v.sel, v.we, v.addr, v.wdata, ack_cyc, m_pre, m_rwl, m_sae, m_wwl,
                m_oe, wbl_seen, rd_ack, deca_ack, other_ack);
        check({tag, "_ack_cycle"}, ack_cyc, v.exp_ack);
        check({tag, "_pre"}, 32'(m_pre), 32'(v.exp_pre));
        check({tag, "_rwl"}, 32'(m_rwl), 32'(v.exp_rwl));
        check({tag, "_sae"}, 32'(m_sae), 32'(v.exp_sae));
        check({tag, "_wwl"}, 32'(m_wwl), 32'(v.exp_wwl));
        check({tag, "_wbl_oe"}, 32'(m_oe), 32'(v.exp_wwl));
        check({tag, "_rdata"}, 32'(rd_ack), 32'(v.exp_rdata));
        check({tag, "_dec_a"}, 32'(deca_ack), 32'(v.addr));
        check({tag, "_other_ack"}, 32'(other_ack), 32'd0);
        if (v.we) check({tag, "_wbl"}, 32'(wbl_seen), 32'(v.wdata));
    endtask

    initial begin
        bit          r0_drop, r1_drop;
        int          n, first_ack, seen_ack;
        logic [3:0]  order;

        //           sel we addr wdata  rdata  ack pre      rwl      sae      wwl
        vecs[0] = '{1'b0, 1'b1, 3'd5, 8'hA5, 8'h00, 3, 16'h0000, 16'h0000, 16'h0000, 16'h0006};
        vecs[1] = '{1'b1, 1'b0, 3'd2, 8'h00, 8'h3C, 5, 16'h0002, 16'h001C, 16'h0010, 16'h0000};
        vecs[2] = '{1'b0, 1'b1, 3'd3, 8'h5A, 8'h3C, 3, 16'h0000, 16'h0000, 16'h0000, 16'h0006};
        vecs[3] = '{1'b1, 1'b0, 3'd5, 8'h00, 8'hA5, 5, 16'h0002, 16'h001C, 16'h0010, 16'h0000};
        vecs[4] = '{1'b0, 1'b1, 3'd6, 8'h0F, 8'hA5, 3, 16'h0000, 16'h0000, 16'h0000, 16'h0006};
        vecs[5] = '{1'b0, 1'b0, 3'd3, 8'h00, 8'h5A, 5, 16'h0002, 16'h001C, 16'h0010, 16'h0000};
        vecs[6] = '{1'b1, 1'b1, 3'd7, 8'hFF, 8'h5A, 3, 16'h0000, 16'h0000, 16'h0000, 16'h0006};
        vecs[7] = '{1'b1, 1'b0, 3'd6, 8'h00, 8'h0F, 5, 16'h0002, 16'h001C, 16'h0010, 16'h0000};
        vecs[8] = '{1'b0, 1'b0, 3'd7, 8'h00, 8'hFF, 5, 16'h0002, 16'h001C, 16'h0010, 16'h0000};

        for (int i = 0; i < 8; i++) mem[i] = 8'h00;
        mem[2] = 8'h3C;
        rst = 1'b1;
        r0_req = 1'b0; r1_req = 1'b0; r0_we = 1'b0; r1_we = 1'b0;
        r0_addr = 3'd0; r1_addr = 3'd0; r0_wdata = 8'h00; r1_wdata = 8'h00;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("reset_outs", 32'({r0_ack, r1_ack, wwl_en, rwl_en, pre, sae, wbl_oe, dec_a, wbl, rdata}), 32'd0);
        check("reset_outs_b", 32'({b_r0_ack, b_r1_ack, b_wwl_en, b_rwl_en, b_pre, b_sae, b_wbl_oe, b_dec_a, b_wbl, b_rdata}), 32'd0);

        for (int i = 0; i < 9; i++) begin
            check_txn($sformatf("vec%0d", i), 1'b0, vecs[i]);
            @(negedge clk);
        end

        // Reset in the middle of a read: controls drop at once, no ack, rdata cleared.
        @(negedge clk);
        r1_we = 1'b0; r1_addr = 3'd4; r1_req = 1'b1;
        repeat (3) @(negedge clk);
        check("midread_rwl_before", 32'({rwl_en, pre}), 32'b10);
        #2 rst = 1'b1;
        #1 check("midread_ctrl_async", 32'({rwl_en, sae, pre, wwl_en, wbl_oe}), 32'd0);
        check("midread_ctrl_async_b", 32'({b_rwl_en, b_sae, b_pre, b_wwl_en, b_wbl_oe}), 32'd0);
        @(negedge clk);
        r1_req = 1'b0;
        rst = 1'b0;
        check("post_reset_rdata", 32'(rdata), 32'd0);
        check("post_reset_dec_a", 32'(dec_a), 32'd0);
        seen_ack = 0;
        repeat (8) begin
            @(negedge clk);
            if (r0_ack || r1_ack) seen_ack++;
        end
        check("post_reset_no_ack", seen_ack, 0);

        // Simultaneous requests right after reset: r0 first, then alternating.
        @(negedge clk);
        r0_we = 1'b1; r0_addr = 3'd1; r0_wdata = 8'h11; r0_req = 1'b1;
        r1_we = 1'b0; r1_addr = 3'd6; r1_req = 1'b1;
        n = 0; first_ack = -1; order = 4'hF; r0_drop = 1'b0; r1_drop = 1'b0;
        for (int k = 1; k < 100; k++) begin
            @(negedge clk);
            if (r0_drop) begin r0_req = 1'b1; r0_drop = 1'b0; end
            if (r1_drop) begin r1_req = 1'b1; r1_drop = 1'b0; end
            if (r0_ack) begin
                if (n < 4) order[n] = 1'b0;
                if (n == 0) first_ack = k;
                n++; r0_req = 1'b0; r0_drop = 1'b1;
            end
            if (r1_ack) begin
                if (n < 4) order[n] = 1'b1;
                check("tie_rdata", 32'(rdata), 32'h0F);
                n++; r1_req = 1'b0; r1_drop = 1'b1;
            end
            if (n >= 4) break;
        end
        r0_req = 1'b0; r1_req = 1'b0;
        check("tie_grant_count", n, 4);
        check("tie_order", 32'(order), 32'b1010);
        check("tie_first_ack_cycle", first_ack, 3);

        // Parameter sweep on the PRE_CYCLES=3, ACC_CYCLES=1 instance.
        repeat (8) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_txn("sweep_rd", 1'b1,
                  '{1'b1, 1'b0, 3'd2, 8'h00, 8'h3C, 6, 16'h000E, 16'h0030, 16'h0020, 16'h0000});
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_txn("sweep_wr", 1'b1,
                  '{1'b0, 1'b1, 3'd4, 8'h44, 8'h00, 2, 16'h0000, 16'h0000, 16'h0000, 16'h0002});
        repeat (4) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
